// File: rtl/vip_axi4_rd_slave_resp.sv
// -----------------------------------------------------------------------------
// vip_axi4_rd_slave_resp
//
// AXI4 read-channel responder. Accepts one read burst at a time on AR, walks
// the burst addresses (FIXED / INCR / WRAP) and reads a word-organised
// synchronous RAM with one cycle of read latency. The returned words go through
// a 2-entry output buffer that drives the R channel, so R backpressure is fully
// supported and no beat is ever dropped.
//
// Optional feature (macro VIP_AXI4_RD_SLAVE_ERR_CHECK_EN):
//   defined   - illegal bursts (reserved burst type, oversize beats, WRAP with
//               an illegal length, INCR crossing 4 KB) become error bursts:
//               same beat count and rlast, every beat SLVERR with rdata = 0,
//               and no memory reads.
//   undefined - no checking; reserved bursts behave as INCR, rresp is OKAY.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   ar*                AXI4 read address channel (slave side)
//   r*                 AXI4 read data channel (slave side)
//   mem_rd_en/addr     RAM read strobe and word address
//   mem_rd_data        RAM read data, valid the cycle after mem_rd_en
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. Once rvalid is raised, rvalid/rid/rdata/rresp/rlast stay
// stable until rready is seen high. arready is high only in IDLE.
// -----------------------------------------------------------------------------
module vip_axi4_rd_slave_resp #(
  parameter int ID_WIDTH_P       = 4,
  parameter int ADDR_WIDTH_P     = 32,
  parameter int DATA_WIDTH_P     = 32,
  parameter int MEM_ADDR_WIDTH_P = ADDR_WIDTH_P - $clog2(DATA_WIDTH_P / 8)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ID_WIDTH_P-1:0]       arid,
  input  logic [ADDR_WIDTH_P-1:0]     araddr,
  input  logic [7:0]                  arlen,
  input  logic [2:0]                  arsize,
  input  logic [1:0]                  arburst,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [ID_WIDTH_P-1:0]       rid,
  output logic [DATA_WIDTH_P-1:0]     rdata,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready,
  output logic                        mem_rd_en,
  output logic [MEM_ADDR_WIDTH_P-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH_P-1:0]     mem_rd_data
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH_P / 8);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic [ID_WIDTH_P-1:0]   id;
    logic [DATA_WIDTH_P-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } beat_t;

  state_e state_q, state_d;

  // Latched burst descriptor
  logic [ID_WIDTH_P-1:0]   id_q;
  logic [ADDR_WIDTH_P-1:0] addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_q;
  logic [7:0]              beat_cnt_q;
  logic                    issue_active_q;  // beats still to be issued

  // Read in flight: data arrives on mem_rd_data this cycle
  logic pend_valid_q;
  logic pend_last_q;
  logic pend_err_q;

  // 2-entry output buffer
  beat_t      fifo_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;

  logic                    ar_hs;
  logic                    pop;
  logic                    issue;
  logic                    ar_err;
  logic [2:0]              occ_after_pop;
  logic [ADDR_WIDTH_P-1:0] size_b;
  logic [ADDR_WIDTH_P-1:0] span;
  logic [ADDR_WIDTH_P-1:0] wrap_low;
  logic [ADDR_WIDTH_P-1:0] wrap_inc;
  logic [ADDR_WIDTH_P-1:0] incr_next;
  logic [ADDR_WIDTH_P-1:0] next_addr;
  beat_t                   push_beat;

  assign ar_hs = arvalid & arready;
  assign pop   = rvalid & rready;

  // Occupancy the buffer will have once the in-flight read lands and the
  // current pop retires. A new read is only allowed if it still fits.
  assign occ_after_pop = {1'b0, count_q} + {2'b00, pend_valid_q} - {2'b00, pop};
  assign issue = (state_q == ST_BURST) && issue_active_q && (occ_after_pop < 3'd2);

  // ---------------------------------------------------------------------------
  // Burst legality check on the incoming AR request
  // ---------------------------------------------------------------------------
`ifdef VIP_AXI4_RD_SLAVE_ERR_CHECK_EN
  logic [ADDR_WIDTH_P-1:0] ar_size_b;
  logic [ADDR_WIDTH_P-1:0] ar_last_byte;

  assign ar_size_b    = ADDR_WIDTH_P'(1) << arsize;
  assign ar_last_byte = (araddr & ~(ar_size_b - ADDR_WIDTH_P'(1)))
                      + ar_size_b * (ADDR_WIDTH_P'(arlen) + ADDR_WIDTH_P'(1))
                      - ADDR_WIDTH_P'(1);
  assign ar_err = (arburst == BURST_RSVD)
               || (arsize > 3'(BYTE_SHIFT))
               || ((arburst == BURST_WRAP) && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
               || ((arburst == BURST_INCR) && ((araddr >> 12) != (ar_last_byte >> 12)));
`else
  assign ar_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next beat address
  // ---------------------------------------------------------------------------
  assign size_b    = ADDR_WIDTH_P'(1) << size_q;
  assign span      = size_b * (ADDR_WIDTH_P'(len_q) + ADDR_WIDTH_P'(1));
  assign wrap_low  = addr_q & ~(span - ADDR_WIDTH_P'(1));
  assign wrap_inc  = addr_q + size_b;
  // First INCR beat may be unaligned; aligning before the add fixes that.
  assign incr_next = (addr_q & ~(size_b - ADDR_WIDTH_P'(1))) + size_b;

  always_comb begin
    next_addr = incr_next;  // INCR and (unchecked) reserved
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = ((wrap_inc - wrap_low) >= span) ? wrap_low : wrap_inc;
      default:     next_addr = incr_next;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ar_hs) state_d = ST_BURST;
      ST_BURST: if (pop && rlast) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // Held low while reset is asserted so reset-time outputs are all zero.
    arready     = (state_q == ST_IDLE) && !rst;
    mem_rd_en   = issue && !err_q;
    mem_rd_addr = MEM_ADDR_WIDTH_P'(addr_q >> BYTE_SHIFT);
    rvalid      = (count_q != 2'd0);
    rid         = fifo_q[rd_ptr_q].id;
    rdata       = fifo_q[rd_ptr_q].data;
    rresp       = fifo_q[rd_ptr_q].resp;
    rlast       = fifo_q[rd_ptr_q].last;
  end

  // ---------------------------------------------------------------------------
  // Burst tracking and issue stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q           <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      size_q         <= '0;
      burst_q        <= '0;
      err_q          <= 1'b0;
      beat_cnt_q     <= '0;
      issue_active_q <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_last_q    <= 1'b0;
      pend_err_q     <= 1'b0;
    end else begin
      pend_valid_q <= issue;
      pend_last_q  <= issue && (beat_cnt_q == 8'd0);
      pend_err_q   <= issue && err_q;
      if (ar_hs) begin
        id_q           <= arid;
        addr_q         <= araddr;
        len_q          <= arlen;
        size_q         <= arsize;
        burst_q        <= arburst;
        err_q          <= ar_err;
        beat_cnt_q     <= arlen;
        issue_active_q <= 1'b1;
      end else if (issue) begin
        addr_q <= next_addr;
        if (beat_cnt_q == 8'd0) issue_active_q <= 1'b0;
        else                    beat_cnt_q     <= beat_cnt_q - 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    push_beat.id   = id_q;
    push_beat.data = pend_err_q ? '0 : mem_rd_data;
    push_beat.resp = pend_err_q ? RESP_SLVERR : RESP_OKAY;
    push_beat.last = pend_last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (pend_valid_q) begin
        fifo_q[wr_ptr_q] <= push_beat;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, pend_valid_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_vip_axi4_rd_slave_resp.sv
`timescale 1ns/1ps
module tb_vip_axi4_rd_slave_resp;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAW = 30;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rst;
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid;
  logic           arready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;
  logic           mem_rd_en;
  logic [MAW-1:0] mem_rd_addr;
  logic [DW-1:0]  mem_rd_data = '0;

  always #5 clk = ~clk;

  vip_axi4_rd_slave_resp #(
    .ID_WIDTH_P(IDW), .ADDR_WIDTH_P(AW), .DATA_WIDTH_P(DW), .MEM_ADDR_WIDTH_P(MAW)
  ) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  // RAM model: word[i] = i, one cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= DW'(mem_rd_addr);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0]  exp_q[$];
  logic [1:0]     exp_resp_q[$];
  logic           exp_last_q[$];
  logic [MAW-1:0] exp_addr_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: beat i address computed directly from the burst rules.
  task automatic build_model(input logic [AW-1:0] addr, input int len,
                             input int size, input logic [1:0] burst,
                             output bit err);
    logic [AW-1:0] sz, span, low, aligned, a, last_byte;
    int nb;
    nb      = len + 1;
    sz      = AW'(1) << size;
    aligned = addr & ~(sz - 1);
    err     = 1'b0;
`ifdef VIP_AXI4_RD_SLAVE_ERR_CHECK_EN
    last_byte = aligned + sz * AW'(nb) - 1;
    if (burst == 2'b11 || size > 2 ||
        (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
        (burst == 2'b01 && addr[AW-1:12] != last_byte[AW-1:12]))
      err = 1'b1;
`else
    last_byte = '0;
`endif
    span = sz * AW'(nb);
    low  = addr & ~(span - 1);
    for (int i = 0; i < nb; i++) begin
      case (burst)
        2'b00:   a = addr;
        2'b10:   a = low + ((addr - low + AW'(i) * sz) % span);
        default: a = (i == 0) ? addr : aligned + AW'(i) * sz;
      endcase
      exp_q.push_back(err ? '0 : DW'(a >> 2));
      exp_resp_q.push_back(err ? 2'b10 : 2'b00);
      exp_last_q.push_back(i == len);
      if (!err) exp_addr_q.push_back(MAW'(a >> 2));
    end
  endtask

  // mode 0: rready always 1, 1: random rready, 2: rready low on cycles 4..9
  task automatic run_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                           input int len, input int size, input logic [1:0] burst,
                           input int mode);
    bit err;
    int nb, cyc, beats, reads, first_cyc, last_cyc;
    bit held;
    logic [IDW-1:0] h_id;
    logic [DW-1:0]  h_data, e_data;
    logic [1:0]     h_resp, e_resp;
    logic           h_last, e_last;
    logic [MAW-1:0] e_addr;
    build_model(addr, len, size, burst, err);
    nb = len + 1;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size);
    arburst = burst; arvalid = 1'b1; rready = 1'b1;
    checks++;
    if (arready !== 1'b1) begin
      errors++; $display("FAIL ar_ready_idle got %b want 1", arready);
    end
    tick();
    arvalid = 1'b0;
    cyc = 1; beats = 0; reads = 0; first_cyc = -1; last_cyc = -1; held = 1'b0;
    while (beats < nb && cyc < 200) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = 1'($urandom_range(0, 1));
        default: rready = !(cyc >= 4 && cyc <= 9);
      endcase
      #1;
      if (mem_rd_en === 1'b1) begin
        reads++;
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++; $display("FAIL rd_addr_extra cycle %0d got %h want no read", cyc, mem_rd_addr);
        end else begin
          e_addr = exp_addr_q.pop_front();
          if (mem_rd_addr !== e_addr) begin
            errors++; $display("FAIL rd_addr cycle %0d got %h want %h", cyc, mem_rd_addr, e_addr);
          end
        end
      end
      if (held) begin
        checks++;
        if ({rvalid, rid, rdata, rresp, rlast} !== {1'b1, h_id, h_data, h_resp, h_last}) begin
          errors++; $display("FAIL r_hold cycle %0d got %b %h %h %b %b want 1 %h %h %b %b",
                             cyc, rvalid, rid, rdata, rresp, rlast, h_id, h_data, h_resp, h_last);
        end
      end
      held = 1'b0;
      if (rvalid === 1'b1 && first_cyc < 0) first_cyc = cyc;
      if (rvalid === 1'b1 && rready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL r_extra cycle %0d got %h want no beat", cyc, rdata);
        end else begin
          e_data = exp_q.pop_front();
          e_resp = exp_resp_q.pop_front();
          e_last = exp_last_q.pop_front();
          if ({rid, rdata, rresp, rlast} !== {id, e_data, e_resp, e_last}) begin
            errors++; $display("FAIL r_beat %0d got id %h data %h resp %b last %b want id %h data %h resp %b last %b",
                               beats, rid, rdata, rresp, rlast, id, e_data, e_resp, e_last);
          end
        end
        beats++;
        if (beats == nb) last_cyc = cyc;
      end else if (rvalid === 1'b1) begin
        held = 1'b1; h_id = rid; h_data = rdata; h_resp = rresp; h_last = rlast;
      end
      checks++;
      if (reads - beats > 2) begin
        errors++; $display("FAIL reads_ahead cycle %0d got %0d want <= 2", cyc, reads - beats);
      end
      tick();
      cyc++;
    end
    checks++;
    if (beats != nb) begin
      errors++; $display("FAIL burst_timeout got %0d beats want %0d", beats, nb);
    end
    rready = 1'b1;
    #1;
    checks++;
    if ({arready, rvalid} !== 2'b10) begin
      errors++; $display("FAIL ar_return got arready %b rvalid %b want 1 0", arready, rvalid);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("FAIL reads_missing got %0d outstanding want 0", exp_addr_q.size());
    end
    if (mode == 0) begin
      checks++;
      if (first_cyc != 3 || last_cyc != 3 + len) begin
        errors++; $display("FAIL stream_timing got first %0d last %0d want 3 %0d", first_cyc, last_cyc, 3 + len);
      end
    end
    exp_q.delete(); exp_resp_q.delete(); exp_last_q.delete(); exp_addr_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; arvalid = 1'b0; rready = 1'b0; arid = '0; araddr = '0;
    arlen = '0; arsize = '0; arburst = '0;
    tick(); tick();
    checks++;
    if ({arready, rvalid, rlast, rdata, rid, rresp, mem_rd_en, mem_rd_addr} !== '0) begin
      errors++; $display("FAIL reset_outputs got %b %b %b %h %h %b %b %h want all zero",
                         arready, rvalid, rlast, rdata, rid, rresp, mem_rd_en, mem_rd_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (arready !== 1'b1) begin
      errors++; $display("FAIL reset_release_arready got %b want 1", arready);
    end
  endtask

  task automatic test_incr();
    run_burst(4'h3, 32'h100, 3, 2, 2'b01, 0);
  endtask

  task automatic test_wrap();
    run_burst(4'h5, 32'h10C, 3, 2, 2'b10, 0);
  endtask

  task automatic test_fixed_unaligned();
    run_burst(4'h1, 32'h20, 2, 2, 2'b00, 0);
    run_burst(4'h2, 32'h101, 1, 1, 2'b01, 0);
  endtask

  task automatic test_backpressure();
    run_burst(4'h7, 32'h0, 7, 2, 2'b01, 2);
  endtask

  task automatic test_config();
`ifdef VIP_AXI4_RD_SLAVE_ERR_CHECK_EN
    run_burst(4'h9, 32'h100, 1, 2, 2'b11, 0);   // reserved burst
    run_burst(4'ha, 32'h100, 1, 3, 2'b01, 0);   // oversize beat
    run_burst(4'hb, 32'h100, 2, 2, 2'b10, 0);   // illegal wrap length
    run_burst(4'hc, 32'hFF8, 3, 2, 2'b01, 0);   // crosses 4 KB
`else
    run_burst(4'h9, 32'h100, 1, 2, 2'b11, 0);   // reserved acts as INCR
`endif
  endtask

  task automatic test_reset_mid_burst();
    arid = 4'h6; araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) tick();  // now in cycle 5, beat 2 on R
    rst = 1'b1;
    tick();
    checks++;
    if ({arready, rvalid, rlast, rdata, rid, rresp, mem_rd_en, mem_rd_addr} !== '0) begin
      errors++; $display("FAIL midburst_reset got %b %b %b %h %h %b %b %h want all zero",
                         arready, rvalid, rlast, rdata, rid, rresp, mem_rd_en, mem_rd_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (arready !== 1'b1) begin
      errors++; $display("FAIL midburst_release_arready got %b want 1", arready);
    end
    run_burst(4'h4, 32'h100, 0, 2, 2'b01, 0);
  endtask

  task automatic test_random();
    logic [1:0]    burst;
    logic [AW-1:0] addr;
    int len, size;
    int wrap_lens[4] = '{1, 3, 7, 15};
    for (int n = 0; n < 40; n++) begin
`ifdef VIP_AXI4_RD_SLAVE_ERR_CHECK_EN
      burst = 2'($urandom_range(0, 3));
      size  = $urandom_range(0, 3);
`else
      burst = 2'($urandom_range(0, 2));
      size  = $urandom_range(0, 2);
`endif
      len  = (burst == 2'b10) ? wrap_lens[$urandom_range(0, 3)] : $urandom_range(0, 15);
      addr = AW'($urandom_range(0, 16'h3FFF));
      if (burst == 2'b10) addr = addr & ~((AW'(1) << size) - 1);
      run_burst(4'($urandom_range(0, 15)), addr, len, size, burst, 1);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_unaligned();
    test_backpressure();
    test_config();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
